// File: rtl/hazard_scheduler.sv
// hazard_scheduler: decode->execute sequencer deciding issue, load-use stall or wrong-path kill, plus forwarding selects.
// Optional HAZARD_PERF_CNT_EN adds stall/kill cycle counters perf_stall_o/perf_kill_o.
module hazard_scheduler #(
  parameter int REG_AW     = 5,
  parameter int LU_BUBBLES = 1,
  parameter int BR_KILL    = 2,
  parameter int JMP_KILL   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic [7:0]        id_ctrl_i,
  input  logic              id_flush_cs_i,
  input  logic              ex_br_taken_i,
  output logic              ex_valid_o,
  output logic              fetch_stall_o,
  output logic              fetch_kill_o,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]       perf_stall_o,
  output logic [31:0]       perf_kill_o,
`endif
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o
);
  typedef enum logic [1:0] {RUN, STALL, KILL} state_e;
  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wr;
    logic              ld;
  } sb_t;
  localparam logic [1:0] LU_C  = 2'(LU_BUBBLES - 1);
  localparam logic [1:0] BR_C  = 2'(BR_KILL - 1);
  localparam logic [1:0] JMP_C = 2'(JMP_KILL - 1);
  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d, cnt_dec;
  logic       init_q;
  sb_t        ex_q, ex_d, mem_q;
  logic       load_use;
  logic       unused_ctrl;
  assign unused_ctrl = ^{id_ctrl_i[7:4], id_ctrl_i[2:1]};
  // A load in EX cannot be forwarded, so any consumer must wait a cycle
  assign load_use = id_valid_i & ex_q.v & ex_q.ld & (|ex_q.rd) &
                    ((ex_q.rd == id_rs1_i) | (ex_q.rd == id_rs2_i));
  assign cnt_dec  = (cnt_q == 2'd0) ? 2'd0 : cnt_q - 2'd1;
  function automatic logic [1:0] fwd_sel(logic [REG_AW-1:0] rs, sb_t ex, sb_t mem);
    return (rs == '0) ? 2'b00 :
           (ex.v & ex.wr & (ex.rd == rs)) ? (ex.ld ? 2'b00 : 2'b01) :
           (mem.v & mem.wr & (mem.rd == rs)) ? 2'b10 : 2'b00;
  endfunction
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    id_ready_o    = 1'b0;
    fetch_stall_o = 1'b0;
    fetch_kill_o  = 1'b0;
    if (init_q) begin
      if (ex_br_taken_i) begin
        fetch_kill_o = 1'b1;
        cnt_d        = BR_C;
        state_d      = (BR_C != 2'd0) ? KILL : RUN;
      end else if (state_q == STALL) begin
        fetch_stall_o = 1'b1;
        cnt_d         = cnt_dec;
        state_d       = (cnt_dec == 2'd0) ? RUN : STALL;
      end else if (state_q == KILL) begin
        fetch_kill_o = 1'b1;
        cnt_d        = cnt_dec;
        state_d      = (cnt_dec == 2'd0) ? RUN : KILL;
      end else if (load_use) begin
        fetch_stall_o = 1'b1;
        cnt_d         = LU_C;
        state_d       = (LU_C != 2'd0) ? STALL : RUN;
      end else begin
        id_ready_o = 1'b1;
        if (id_valid_i & id_flush_cs_i) begin
          fetch_kill_o = 1'b1;
          cnt_d        = JMP_C;
          state_d      = (JMP_C != 2'd0) ? KILL : RUN;
        end
      end
    end
  end
  assign ex_d       = (id_valid_i & id_ready_o) ? {1'b1, id_rd_i, id_ctrl_i[0], id_ctrl_i[3]} : '0;
  assign ex_valid_o = ex_q.v;
  assign fwd_a_o    = fwd_sel(id_rs1_i, ex_q, mem_q);
  assign fwd_b_o    = fwd_sel(id_rs2_i, ex_q, mem_q);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q  <= 1'b0;
      state_q <= RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
      mem_q   <= '0;
    end else begin
      init_q  <= 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= ex_q;
    end
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_kill_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= '0;
      perf_kill_q  <= '0;
    end else begin
      perf_stall_q <= perf_stall_q + {31'd0, fetch_stall_o};
      perf_kill_q  <= perf_kill_q + {31'd0, fetch_kill_o};
    end
  end
  assign perf_stall_o = perf_stall_q;
  assign perf_kill_o  = perf_kill_q;
`endif
endmodule
